intra_scan_ctrl: RTL and testbench
==================================

Name: intra_scan_ctrl

Overview:
Frame scan scheduler for the intra prediction/reconstruction loop (`intraloop`). It generates 4x4 luma block coordinates in H.264 decoding order: macroblocks in raster order, and the 16 4x4 blocks inside each macroblock in standard blkIdx (double-Z) order. Each coordinate is presented on a valid/ready handshake as `mbnumber = {row, col}`. Downstream stalls via ready until the previous block's reconstruction is available for neighbour prediction.

Parameters:
- WIDTH, 1280, frame width in luma pixels; must be a multiple of 16.
- LENGTH, 720, frame height in luma pixels; must be a multiple of 16.
- CW, 16, width of the row and col coordinate fields.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a frame scan when idle.
- abort  in  1  synchronous abort; returns the block to IDLE with no frame_done.
- blk_valid  out  1  mbnumber/blk_idx are valid.
- blk_ready  in  1  downstream accepts the current block.
- mbnumber  out  2*CW  {row[CW-1:0], col[CW-1:0]}, top-left pixel of the 4x4 block.
- blk_idx  out  4  H.264 luma4x4BlkIdx within the current MB.
- mb_first  out  1  high when blk_idx==0 (new MB).
- frame_done  out  1  one-cycle pulse after the last block handshake.
- busy  out  1  high in RUN.

Behaviour:
- Reset values:
  - state=IDLE.
  - blk_valid=0, mbnumber=0, blk_idx=0, mb_first=0, frame_done=0, busy=0.
  - All counters are 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start. All counters load 0.
  - In RUN, blk_valid=1 and busy=1 from the first cycle after start was sampled (latency 1). The first output is mbnumber=0x00000000, blk_idx=0.
  - RUN -> DONE on handshake (blk_valid & blk_ready) of the last block.
  - DONE lasts exactly 1 cycle with frame_done=1, blk_valid=0, then goes to IDLE.
- Counters:
  - mb_x runs 0..WIDTH/16-1.
  - mb_y runs 0..LENGTH/16-1.
  - blk runs 0..15.
  - On each handshake, blk increments. When blk wraps 15->0, mb_x increments. When mb_x wraps, it goes to 0 and mb_y increments.
- Coordinate mapping (pure bit slicing, no multiplier):
  - col = mb_x*16 + blk[2]*8 + blk[0]*4
  - row = mb_y*16 + blk[3]*8 + blk[1]*4
- Outputs mbnumber, blk_idx and mb_first are registered and update only on a handshake. They hold stable while blk_valid & !blk_ready (AXI-style: no retraction, no change while stalled).
- blk_ready is ignored when blk_valid=0.
- start is ignored in RUN and DONE. In DONE, a start is dropped and must be reissued from IDLE.
- abort:
  - In RUN, the next state is IDLE, blk_valid=0 and frame_done is not pulsed.
  - abort has priority over a simultaneous final handshake.
  - abort together with start in IDLE: abort wins, the block stays IDLE.
- reset has priority over abort and start. Reset mid-frame fully restarts: the next start scans from (0,0).
- Coordinate arithmetic is CW bits wide and unsigned. Elaboration-time assertions:
  - WIDTH%16==0 and LENGTH%16==0.
  - WIDTH and LENGTH are each < 2**CW.
- Total handshakes per frame = (WIDTH/16)*(LENGTH/16)*16; for the defaults this is 57600.

Decomposition:
- Shared package `h264_pkg` holds:
  - MB_SIZE=16 and BLK_SIZE=4.
  - typedef `coord_t` (logic [CW-1:0]).
  - enum `scan_state_e` {IDLE, RUN, DONE}.
  - function `blk4x4_offset(idx)`, returning {y_off, x_off}; this is reusable by the intra predictor.
- One natural sub-module, `mb_scan_counter`: the cascaded blk/mb_x/mb_y counters with an advance input and a last flag. The FSM and output registers stay in `intra_scan_ctrl`.

Test Plan:
1. reset 2 cycles, start pulse, blk_ready=1 → blk_valid rises 1 cycle later; mbnumber sequence is 0x00000000, 0x00000004, 0x00040000, 0x00040004, 0x00000008, with blk_idx 0..4.
2. Continue through MB0 → blk_idx=15 gives mbnumber=0x000C000C. The next block is 0x00000010 with mb_first=1, blk_idx=0.
3. Row wrap (defaults) → the last block of MB row 0 is 0x000C04FC. The next block is 0x00100000 with mb_first=1.
4. Backpressure: drop blk_ready for 3 cycles mid-MB → blk_valid stays 1, mbnumber and blk_idx stay unchanged; the scan resumes with no skipped or repeated block (scoreboard over the full frame, 57600 unique coords).
5. End of frame (defaults, plus WIDTH=32/LENGTH=16 for a fast run) → the last block is 0x02CC04FC (small config: 0x000C001C). frame_done pulses exactly 1 cycle after that handshake; busy=0; blk_valid=0; a start during DONE is ignored.
6. abort, and separately reset, asserted mid-frame at block 100 → blk_valid=0 next cycle and no frame_done. A new start restarts at 0x00000000, blk_idx=0.

Source files
------------

// File: rtl/h264_pkg.sv
// Shared H.264 constants, types and helpers used by the intra prediction/reconstruction loop.
package h264_pkg;

  localparam int MB_SIZE  = 16;
  localparam int BLK_SIZE = 4;
  localparam int CW_DEF   = 16;

  typedef logic [CW_DEF-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  // luma4x4BlkIdx -> {y_off, x_off}, each in 4x4-block units inside the MB (double-Z order)
  function automatic logic [3:0] blk4x4_offset(input logic [3:0] idx);
    return {idx[3], idx[1], idx[2], idx[0]};
  endfunction

endpackage

// File: rtl/intra_scan_ctrl_chk.sv
// Elaboration-time legality checks on the frame geometry of intra_scan_ctrl.
module intra_scan_ctrl_chk
  import h264_pkg::*;
#(
  parameter int WIDTH  = 1280,
  parameter int LENGTH = 720,
  parameter int CW     = 16
) ();

  generate
    if (((WIDTH % MB_SIZE) != 0) || ((LENGTH % MB_SIZE) != 0)) begin : g_bad_multiple
      $error("intra_scan_ctrl: WIDTH and LENGTH must be multiples of %0d", MB_SIZE);
    end
    if ((WIDTH >= (2 ** CW)) || (LENGTH >= (2 ** CW))) begin : g_bad_range
      $error("intra_scan_ctrl: WIDTH and LENGTH must be below 2**CW");
    end
    if ((MB_SIZE % BLK_SIZE) != 0) begin : g_bad_blk
      $error("intra_scan_ctrl: MB_SIZE must be a multiple of BLK_SIZE");
    end
  endgenerate

endmodule

// File: rtl/mb_scan_counter.sv
// Cascaded 4x4-block / MB-column / MB-row counters; the nxt outputs are the values after one advance.
module mb_scan_counter #(
  parameter int MB_COLS = 80,
  parameter int MB_ROWS = 45,
  parameter int MW      = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          advance,
  output logic [3:0]    blk_nxt,
  output logic [MW-1:0] mb_x_nxt,
  output logic [MW-1:0] mb_y_nxt,
  output logic          last
);

  localparam logic [MW-1:0] X_MAX = MW'(MB_COLS - 1);
  localparam logic [MW-1:0] Y_MAX = MW'(MB_ROWS - 1);

  logic [3:0]    blk_r;
  logic [MW-1:0] mb_x_r;
  logic [MW-1:0] mb_y_r;
  logic          blk_wrap_s;
  logic          x_wrap_s;

  // Next-count logic for the blk -> mb_x -> mb_y cascade
  always_comb begin
    blk_wrap_s = (blk_r == 4'd15);
    x_wrap_s   = blk_wrap_s && (mb_x_r == X_MAX);
    blk_nxt    = blk_r + 4'd1;
    if (x_wrap_s) begin
      mb_x_nxt = '0;
    end else if (blk_wrap_s) begin
      mb_x_nxt = mb_x_r + MW'(1);
    end else begin
      mb_x_nxt = mb_x_r;
    end
    if (x_wrap_s && (mb_y_r == Y_MAX)) begin
      mb_y_nxt = '0;
    end else if (x_wrap_s) begin
      mb_y_nxt = mb_y_r + MW'(1);
    end else begin
      mb_y_nxt = mb_y_r;
    end
    last = x_wrap_s && (mb_y_r == Y_MAX);
  end

  // Counter state: cleared at frame start, stepped once per accepted block
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      blk_r  <= 4'd0;
      mb_x_r <= '0;
      mb_y_r <= '0;
    end else if (advance) begin
      blk_r  <= blk_nxt;
      mb_x_r <= mb_x_nxt;
      mb_y_r <= mb_y_nxt;
    end
  end

endmodule

// File: rtl/intra_scan_ctrl.sv
// Frame scan scheduler: emits 4x4 luma block coordinates in H.264 decoding order on a valid/ready handshake.
module intra_scan_ctrl
  import h264_pkg::*;
#(
  parameter int WIDTH  = 1280,
  parameter int LENGTH = 720,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic          blk_valid,
  input  logic          blk_ready,
  output logic [2*CW-1:0] mbnumber,
  output logic [3:0]    blk_idx,
  output logic          mb_first,
  output logic          frame_done,
  output logic          busy
);

  localparam int MW = CW - 4;

  scan_state_e    state_r;
  logic           blk_valid_r;
  logic [2*CW-1:0] mbnumber_r;
  logic [3:0]     blk_idx_r;
  logic           mb_first_r;
  logic           frame_done_r;
  logic           busy_r;

  logic           hs_s;
  logic           clr_s;
  logic           adv_s;
  logic           last_s;
  logic [3:0]     blk_nxt_s;
  logic [3:0]     off_s;
  logic [MW-1:0]  mb_x_nxt_s;
  logic [MW-1:0]  mb_y_nxt_s;
  logic [CW-1:0]  col_nxt_s;
  logic [CW-1:0]  row_nxt_s;

  assign hs_s  = blk_valid_r & blk_ready;
  assign clr_s = (state_r == IDLE) & start & ~abort;
  assign adv_s = (state_r == RUN) & hs_s & ~abort;

  mb_scan_counter #(
    .MB_COLS (WIDTH / MB_SIZE),
    .MB_ROWS (LENGTH / MB_SIZE),
    .MW      (MW)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr_s),
    .advance  (adv_s),
    .blk_nxt  (blk_nxt_s),
    .mb_x_nxt (mb_x_nxt_s),
    .mb_y_nxt (mb_y_nxt_s),
    .last     (last_s)
  );

  intra_scan_ctrl_chk #(.WIDTH(WIDTH), .LENGTH(LENGTH), .CW(CW)) u_chk ();

  // MB origin is a multiple of 16, so the pixel coordinate is pure concatenation
  assign off_s     = blk4x4_offset(blk_nxt_s);
  assign col_nxt_s = {mb_x_nxt_s, off_s[1:0], 2'b00};
  assign row_nxt_s = {mb_y_nxt_s, off_s[3:2], 2'b00};

  // Scan FSM and registered handshake outputs; abort outranks the final handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      blk_valid_r  <= 1'b0;
      mbnumber_r   <= '0;
      blk_idx_r    <= 4'd0;
      mb_first_r   <= 1'b0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (clr_s) begin
            state_r     <= RUN;
            blk_valid_r <= 1'b1;
            busy_r      <= 1'b1;
            mbnumber_r  <= '0;
            blk_idx_r   <= 4'd0;
            mb_first_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (abort) begin
            state_r     <= IDLE;
            blk_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end else if (hs_s && last_s) begin
            state_r      <= DONE;
            blk_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b1;
          end else if (hs_s) begin
            mbnumber_r <= {row_nxt_s, col_nxt_s};
            blk_idx_r  <= blk_nxt_s;
            mb_first_r <= (blk_nxt_s == 4'd0);
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          blk_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign blk_valid  = blk_valid_r;
  assign mbnumber   = mbnumber_r;
  assign blk_idx    = blk_idx_r;
  assign mb_first   = mb_first_r;
  assign frame_done = frame_done_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_intra_scan_ctrl.sv
// Scoreboard bench for intra_scan_ctrl: default 1280x720 instance plus a 32x16 instance for fast end-of-frame cases.
module tb_intra_scan_ctrl;

  typedef struct {
    int          n;
    logic [31:0] mbn;
    logic [3:0]  idx;
    logic        first;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, abort, blk_ready;
  logic        blk_valid, mb_first, frame_done, busy;
  logic [31:0] mbnumber;
  logic [3:0]  blk_idx;

  logic        s_reset, s_start, s_abort, s_ready;
  logic        s_valid, s_first, s_done, s_busy;
  logic [31:0] s_mbn;
  logic [3:0]  s_idx;

  intra_scan_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .mbnumber(mbnumber),
    .blk_idx(blk_idx), .mb_first(mb_first), .frame_done(frame_done), .busy(busy)
  );

  intra_scan_ctrl #(.WIDTH(32), .LENGTH(16), .CW(16)) dut_s (
    .clk(clk), .reset(s_reset), .start(s_start), .abort(s_abort),
    .blk_valid(s_valid), .blk_ready(s_ready), .mbnumber(s_mbn),
    .blk_idx(s_idx), .mb_first(s_first), .frame_done(s_done), .busy(s_busy)
  );

  int   vec_n = 0;
  int   miss_n = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   hs_total = 0;
  int   done_cnt = 0;
  int   s_hs = 0;
  int   s_base = 0;
  int   s_done_cnt = 0;
  int   s_n;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference double-Z order: 8x8 quadrant in raster, then 4x4 in raster inside it
  function automatic logic [31:0] model_coord(input int n, input int mbw);
    int mb, b, i8, j, x, y;
    mb = n / 16;
    b  = n % 16;
    i8 = b / 4;
    j  = b % 4;
    x  = (mb % mbw) * 16 + (i8 % 2) * 8 + (j % 2) * 4;
    y  = (mb / mbw) * 16 + (i8 / 2) * 8 + (j / 2) * 4;
    return {y[15:0], x[15:0]};
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int n = 0; n < 57600; n++) begin
      e.n     = n;
      e.mbn   = model_coord(n, 80);
      e.idx   = 4'(n % 16);
      e.first = ((n % 16) == 0);
      exp_q.push_back(e);
    end
  endtask

  // Monitor for the default instance: pop and compare on every handshake
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (blk_valid && blk_ready) begin
      hs_total++;
      if (exp_q.size() == 0) begin
        vec_n++;
        miss_n++;
        $display("FAIL unexpected_hs: got %h with no expected block", mbnumber);
      end else begin
        mon_e = exp_q.pop_front();
        chk("scoreboard", {mbnumber, blk_idx, mb_first}, {mon_e.mbn, mon_e.idx, mon_e.first});
        case (mon_e.n)
          0:     chk("blk0", {mbnumber, blk_idx, mb_first}, {32'h00000000, 4'd0, 1'b1});
          1:     chk("blk1", {mbnumber, blk_idx}, {32'h00000004, 4'd1});
          2:     chk("blk2", {mbnumber, blk_idx}, {32'h00040000, 4'd2});
          3:     chk("blk3", {mbnumber, blk_idx}, {32'h00040004, 4'd3});
          4:     chk("blk4", {mbnumber, blk_idx}, {32'h00000008, 4'd4});
          15:    chk("mb0_last", {mbnumber, blk_idx}, {32'h000C000C, 4'd15});
          16:    chk("mb1_first", {mbnumber, blk_idx, mb_first}, {32'h00000010, 4'd0, 1'b1});
          1279:  chk("row0_last", mbnumber, 32'h000C04FC);
          1280:  chk("row1_first", {mbnumber, mb_first}, {32'h00100000, 1'b1});
          57599: chk("frame_last", mbnumber, 32'h02CC04FC);
          default: ;
        endcase
      end
    end
  end

  // Monitor for the small instance
  always @(negedge clk) begin
    if (s_done) s_done_cnt++;
    if (s_valid && s_ready) begin
      s_n = s_hs - s_base;
      chk("small_sb", {s_mbn, s_idx, s_first}, {model_coord(s_n, 2), 4'(s_n % 16), ((s_n % 16) == 0)});
      if (s_n == 31) chk("small_last", s_mbn, 32'h000C001C);
      s_hs++;
    end
  end

  initial begin
    int  base;
    int  d0;
    bit  got;
    bit  stalled;
    reset = 1'b1; start = 1'b0; abort = 1'b0; blk_ready = 1'b1;
    s_reset = 1'b1; s_start = 1'b0; s_abort = 1'b0; s_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    s_reset = 1'b0;
    chk("rst_outputs", {blk_valid, mbnumber, blk_idx, mb_first, frame_done, busy}, 64'd0);
    chk("rst_small", {s_valid, s_busy, s_done}, 64'd0);

    // Small frame: full run, then abort colliding with the final handshake
    s_base = s_hs;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    chk("small_latency", {s_valid, s_busy}, 2'b11);
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(posedge clk); #1;
      if ((s_hs - s_base) == 32) begin
        got = 1'b1;
        chk("small_done_pulse", {s_done, s_valid, s_busy}, 3'b100);
      end
    end
    chk("small_end_seen", got, 1'b1);
    @(posedge clk); #1;
    chk("small_done_width", s_done, 1'b0);
    chk("small_done_count", s_done_cnt, 1);

    s_base = s_hs;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int c = 0; c < 200 && (s_hs - s_base) < 31; c++) begin
      @(posedge clk); #1;
    end
    chk("small_at_last", s_hs - s_base, 31);
    s_abort = 1'b1;
    @(posedge clk); #1;
    s_abort = 1'b0;
    chk("small_abort_wins", {s_valid, s_busy, s_done}, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    chk("small_abort_no_done", s_done_cnt, 1);

    // Full default frame with a 3-cycle stall at block 6
    base = hs_total;
    push_frame();
    start = 1'b1;
    chk("pre_start_valid", blk_valid, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_latency", {blk_valid, busy}, 2'b11);
    got = 1'b0;
    stalled = 1'b0;
    for (int c = 0; c < 70000 && !got; c++) begin
      @(posedge clk); #1;
      if (!stalled && (hs_total - base) == 6) begin
        stalled = 1'b1;
        blk_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          chk("stall_hold", {blk_valid, mbnumber, blk_idx}, {1'b1, 32'h00040008, 4'd6});
          chk("stall_no_hs", hs_total - base, 6);
        end
        blk_ready = 1'b1;
      end
      if ((hs_total - base) == 57600) begin
        got = 1'b1;
        chk("frame_done_pulse", {frame_done, blk_valid, busy}, 3'b100);
        start = 1'b1;
      end
    end
    chk("frame_end_seen", got, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_width", {frame_done, busy}, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    chk("start_in_done_dropped", {blk_valid, busy}, 2'b00);
    chk("done_count", done_cnt, 1);
    chk("queue_drained", exp_q.size(), 0);

    // Abort at block 100
    base = hs_total;
    push_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 1000 && (hs_total - base) < 100; c++) begin
      @(posedge clk); #1;
    end
    chk("abort_reached_100", hs_total - base, 100);
    d0 = done_cnt;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    chk("abort_idle", {blk_valid, busy}, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, d0);

    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("abort_beats_start", {blk_valid, busy}, 2'b00);

    // Restart after abort, then reset at block 100
    base = hs_total;
    push_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_first", {blk_valid, mbnumber, blk_idx}, {1'b1, 32'h00000000, 4'd0});
    for (int c = 0; c < 1000 && (hs_total - base) < 100; c++) begin
      @(posedge clk); #1;
    end
    chk("reset_reached_100", hs_total - base, 100);
    d0 = done_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midframe_reset", {blk_valid, mbnumber, blk_idx, mb_first, busy}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_no_done", done_cnt, d0);

    // Restart after reset scans from (0,0)
    base = hs_total;
    push_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("reset_restart_first", {blk_valid, mbnumber, blk_idx, mb_first}, {1'b1, 32'h00000000, 4'd0, 1'b1});
    for (int c = 0; c < 100 && (hs_total - base) < 20; c++) begin
      @(posedge clk); #1;
    end
    chk("reset_restart_progress", hs_total - base, 20);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    chk("final_idle", blk_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule
